jtframe_mister_ddr_arb: RTL and testbench

// - Shares the single MiSTer DDR3 read port (Avalon-style: rd/addr/burstcnt/busy/dout/dout_ready)

---
 rtl/jtframe_mister_ddr_arb_pkg.sv | 18 +
 rtl/jtframe_rr_arb2.sv | 38 +++
 rtl/jtframe_mister_ddr_arb.sv | 174 +++++++++++++++++
 tb/tb_jtframe_mister_ddr_arb.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtframe_mister_ddr_arb_pkg.sv
// Shared FSM encoding, byte-enable constant and burst-length helper for the
// MiSTer DDR read-port arbiter.
package jtframe_mister_ddr_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DATA  = 2'd2
  } state_t;

  localparam logic [7:0] DDR_BE_ALL = 8'hFF;

  // A zero-length burst would never complete on the DDR side, so it becomes one beat.
  function automatic logic [7:0] fix_burstcnt(input logic [7:0] bc);
    return (bc == 8'd0) ? 8'd1 : bc;
  endfunction

endpackage

// File: rtl/jtframe_rr_arb2.sv
// Two-way picker: fixed priority to requester 0, or round-robin where the
// last-granted requester loses a tie. The last grant is remembered here.
module jtframe_rr_arb2
  import jtframe_mister_ddr_arb_pkg::*;
#(
  parameter int PRIO0 = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       upd_i,
  input  logic       upd_gnt_i,
  output logic       gnt_o
);

  logic last_q;

  always_comb begin
    gnt_o = 1'b0;
    if (PRIO0 != 0) begin
      gnt_o = ~req_i[0];
    end else if (req_i == 2'b11) begin
      gnt_o = ~last_q;
    end else begin
      gnt_o = ~req_i[0];
    end
  end

  // Starts at 1 so that requester 0 wins the first tie after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= 1'b1;
    end else if (upd_i) begin
      last_q <= upd_gnt_i;
    end
  end

endmodule

// File: rtl/jtframe_mister_ddr_arb.sv
// Shares the MiSTer DDR3 read port between the ROM download streamer (req0) and
// a secondary reader (req1), one whole burst at a time.
module jtframe_mister_ddr_arb
  import jtframe_mister_ddr_arb_pkg::*;
#(
  parameter int AW    = 29,
  parameter int PRIO0 = 0,
  parameter int TOUT  = 12
) (
  input  logic          rst,
  input  logic          clk,
  input  logic          req0_rd,
  input  logic [AW-1:0] req0_addr,
  input  logic [7:0]    req0_burstcnt,
  output logic          req0_busy,
  output logic [63:0]   req0_dout,
  output logic          req0_dout_ready,
  input  logic          req1_rd,
  input  logic [AW-1:0] req1_addr,
  input  logic [7:0]    req1_burstcnt,
  output logic          req1_busy,
  output logic [63:0]   req1_dout,
  output logic          req1_dout_ready,
  input  logic          ddram_busy,
  output logic          ddram_rd,
  output logic [AW-1:0] ddram_addr,
  output logic [7:0]    ddram_burstcnt,
  output logic [7:0]    ddram_be,
  input  logic [63:0]   ddram_dout,
  input  logic          ddram_dout_ready,
  output logic          err
);

  // One short of all-ones: abort fires on the (2**TOUT-1)-th silent cycle.
  localparam logic [TOUT-1:0] WD_LAST = ~TOUT'(1);

  state_t          state_q;
  logic            gnt_q;
  logic [1:0]      pend_q, pend_d;
  logic [1:0]      busy_q, busy_d;
  logic [AW-1:0]   addr0_q, addr1_q;
  logic [7:0]      bc0_q, bc1_q;
  logic            ddram_rd_q;
  logic [AW-1:0]   ddram_addr_q;
  logic [7:0]      ddram_bc_q;
  logic [7:0]      cnt_q;
  logic [TOUT-1:0] wd_q;
  logic            err_q;
  logic [63:0]     dout_q;
  logic [1:0]      rdy_q;

  logic [1:0] acc;
  logic       rd_bad;
  logic       cmd_ok;
  logic       beat;
  logic       last_beat;
  logic       wd_abort;
  logic       pick;

  jtframe_rr_arb2 #(.PRIO0(PRIO0)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req_i     (pend_q),
    .upd_i     (last_beat | wd_abort),
    .upd_gnt_i (gnt_q),
    .gnt_o     (pick)
  );

  // Request acceptance, completion detection and next pending/busy flags.
  always_comb begin
    acc       = {req1_rd & ~busy_q[1], req0_rd & ~busy_q[0]};
    rd_bad    = (req1_rd & busy_q[1]) | (req0_rd & busy_q[0]);
    cmd_ok    = (state_q == ST_ISSUE) && !ddram_busy;
    beat      = ddram_dout_ready;
    last_beat = (state_q == ST_DATA) && beat && (cnt_q == ddram_bc_q - 8'd1);
    wd_abort  = (state_q == ST_DATA) && !beat && (wd_q == WD_LAST);
    pend_d    = pend_q | acc;
    if (cmd_ok) begin
      pend_d[gnt_q] = 1'b0;
    end else begin
      pend_d = pend_q | acc;
    end
    // Owner term uses the current state so busy drops one clock after the final beat.
    busy_d[0] = pend_d[0] | ((state_q != ST_IDLE) && !gnt_q);
    busy_d[1] = pend_d[1] | ((state_q != ST_IDLE) &&  gnt_q);
  end

  // Request latches, DDR command FSM, beat counter, watchdog and data return.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      gnt_q        <= 1'b0;
      pend_q       <= 2'b00;
      busy_q       <= 2'b00;
      addr0_q      <= '0;
      addr1_q      <= '0;
      bc0_q        <= 8'd0;
      bc1_q        <= 8'd0;
      ddram_rd_q   <= 1'b0;
      ddram_addr_q <= '0;
      ddram_bc_q   <= 8'd0;
      cnt_q        <= 8'd0;
      wd_q         <= '0;
      err_q        <= 1'b0;
      dout_q       <= 64'd0;
      rdy_q        <= 2'b00;
    end else begin
      pend_q   <= pend_d;
      busy_q   <= busy_d;
      err_q    <= rd_bad | wd_abort;
      rdy_q[0] <= beat && (state_q == ST_DATA) && !gnt_q;
      rdy_q[1] <= beat && (state_q == ST_DATA) &&  gnt_q;
      if (beat) begin
        dout_q <= ddram_dout;
      end
      if (acc[0]) begin
        addr0_q <= req0_addr;
        bc0_q   <= fix_burstcnt(req0_burstcnt);
      end
      if (acc[1]) begin
        addr1_q <= req1_addr;
        bc1_q   <= fix_burstcnt(req1_burstcnt);
      end
      case (state_q)
        ST_IDLE: begin
          if (pend_q != 2'b00) begin
            gnt_q        <= pick;
            ddram_rd_q   <= 1'b1;
            ddram_addr_q <= pick ? addr1_q : addr0_q;
            ddram_bc_q   <= pick ? bc1_q : bc0_q;
            state_q      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (!ddram_busy) begin
            ddram_rd_q <= 1'b0;
            cnt_q      <= 8'd0;
            wd_q       <= '0;
            state_q    <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (beat) begin
            cnt_q <= cnt_q + 8'd1;
            wd_q  <= '0;
            if (last_beat) begin
              state_q <= ST_IDLE;
            end
          end else if (wd_abort) begin
            state_q <= ST_IDLE;
          end else if (wd_q != '1) begin
            wd_q <= wd_q + TOUT'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign req0_busy       = busy_q[0];
  assign req1_busy       = busy_q[1];
  assign req0_dout       = dout_q;
  assign req1_dout       = dout_q;
  assign req0_dout_ready = rdy_q[0];
  assign req1_dout_ready = rdy_q[1];
  assign ddram_rd        = ddram_rd_q;
  assign ddram_addr      = ddram_addr_q;
  assign ddram_burstcnt  = ddram_bc_q;
  assign ddram_be        = DDR_BE_ALL;
  assign err             = err_q;

endmodule

// File: tb/tb_jtframe_mister_ddr_arb.sv
// Directed bench: dut_a is round-robin, dut_b fixed-priority; both share all inputs.
module tb_jtframe_mister_ddr_arb;
  localparam int AW = 29;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [1:0]      rd = 2'b00;
  logic [AW-1:0]   raddr [2];
  logic [7:0]      rbc [2];
  logic            ddram_busy = 1'b0;
  logic            ddram_dout_ready = 1'b0;
  logic [63:0]     ddram_dout = 64'd0;

  logic [1:0]      a_busy, a_rdy, b_busy, b_rdy;
  logic [63:0]     a_dout0, a_dout1, b_dout0, b_dout1;
  logic            a_rd, b_rd, a_err, b_err;
  logic [AW-1:0]   a_addr, b_addr;
  logic [7:0]      a_bc, b_bc, a_be, b_be;

  int total = 0;
  int bad = 0;
  int r0_cnt = 0, r1_cnt = 0, acc_cnt = 0, err_cnt = 0;

  always #5 clk = ~clk;

  jtframe_mister_ddr_arb #(.AW(AW), .PRIO0(0), .TOUT(4)) dut_a (
    .rst(rst), .clk(clk),
    .req0_rd(rd[0]), .req0_addr(raddr[0]), .req0_burstcnt(rbc[0]),
    .req0_busy(a_busy[0]), .req0_dout(a_dout0), .req0_dout_ready(a_rdy[0]),
    .req1_rd(rd[1]), .req1_addr(raddr[1]), .req1_burstcnt(rbc[1]),
    .req1_busy(a_busy[1]), .req1_dout(a_dout1), .req1_dout_ready(a_rdy[1]),
    .ddram_busy(ddram_busy), .ddram_rd(a_rd), .ddram_addr(a_addr),
    .ddram_burstcnt(a_bc), .ddram_be(a_be), .ddram_dout(ddram_dout),
    .ddram_dout_ready(ddram_dout_ready), .err(a_err)
  );

  jtframe_mister_ddr_arb #(.AW(AW), .PRIO0(1), .TOUT(4)) dut_b (
    .rst(rst), .clk(clk),
    .req0_rd(rd[0]), .req0_addr(raddr[0]), .req0_burstcnt(rbc[0]),
    .req0_busy(b_busy[0]), .req0_dout(b_dout0), .req0_dout_ready(b_rdy[0]),
    .req1_rd(rd[1]), .req1_addr(raddr[1]), .req1_burstcnt(rbc[1]),
    .req1_busy(b_busy[1]), .req1_dout(b_dout1), .req1_dout_ready(b_rdy[1]),
    .ddram_busy(ddram_busy), .ddram_rd(b_rd), .ddram_addr(b_addr),
    .ddram_burstcnt(b_bc), .ddram_be(b_be), .ddram_dout(ddram_dout),
    .ddram_dout_ready(ddram_dout_ready), .err(b_err)
  );

  // Event counters for dut_a, sampled mid-cycle.
  always @(negedge clk) begin
    if (a_rdy[0]) r0_cnt++;
    if (a_rdy[1]) r1_cnt++;
    if (a_rd && !ddram_busy) acc_cnt++;
    if (a_err) err_cnt++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] pat(input int p, input int i);
    return {32'(p), 32'(i)} ^ 64'h5A5A_0F0F_C3C3_0000;
  endfunction

  task automatic pulse(input int p, input logic [AW-1:0] ad, input logic [7:0] b);
    rd[p] = 1'b1;
    raddr[p] = ad;
    rbc[p] = b;
    tick();
    rd[p] = 1'b0;
  endtask

  task automatic issue(input int nbusy, output logic [AW-1:0] ad_a, output logic [AW-1:0] ad_b,
                       output logic [7:0] bc_a, output int rdcyc);
    int w;
    w = 0;
    while (!a_rd && w < 8) begin
      tick();
      w++;
    end
    chk("cmd_seen", 64'(a_rd), 64'd1);
    ad_a = a_addr;
    ad_b = b_addr;
    bc_a = a_bc;
    rdcyc = 1;
    ddram_busy = (nbusy > 0);
    for (int i = 0; i < nbusy; i++) begin
      tick();
      if (a_rd) rdcyc++;
      chk("hold_addr", 64'(a_addr), 64'(ad_a));
      chk("hold_bc", 64'(a_bc), 64'(bc_a));
    end
    ddram_busy = 1'b0;
    tick();
    if (a_rd) rdcyc++;
  endtask

  task automatic beats(input int p, input int n, input bit fin);
    for (int i = 0; i < n; i++) begin
      ddram_dout = pat(p, i);
      ddram_dout_ready = 1'b1;
      tick();
      chk("beat_rdy", 64'(a_rdy[p]), 64'd1);
      chk("beat_data", (p == 1) ? a_dout1 : a_dout0, pat(p, i));
    end
    ddram_dout_ready = 1'b0;
    if (fin) begin
      chk("busy_hold", 64'(a_busy[p]), 64'd1);
      tick();
      chk("busy_fall", 64'(a_busy[p]), 64'd0);
      chk("rdy_fall", 64'(a_rdy[p]), 64'd0);
    end
  endtask

  typedef struct {
    int            p;
    logic [AW-1:0] addr;
    logic [7:0]    bc;
    logic [7:0]    ebc;
    int            nbeat;
    int            nbusy;
  } vec_t;

  vec_t vt [5];

  initial begin
    logic [AW-1:0] ad_a, ad_b;
    logic [7:0]    bc_a;
    int rdc, s0, s1, sa, se, n;
    bit got;

    vt[0] = '{0, 29'h3000000,  8'd128, 8'd128, 128, 0};
    vt[1] = '{1, 29'h0000123,  8'd0,   8'd1,   1,   0};
    vt[2] = '{0, 29'h1FFFFFFF, 8'd1,   8'd1,   1,   5};
    vt[3] = '{1, 29'h0ABCDEF,  8'd255, 8'd255, 255, 2};
    vt[4] = '{0, 29'h0000040,  8'd8,   8'd8,   8,   0};

    raddr[0] = '0; raddr[1] = '0; rbc[0] = 8'd0; rbc[1] = 8'd0;

    tick(); tick();
    chk("rst_rd", 64'(a_rd), 64'd0);
    chk("rst_addr", 64'(a_addr), 64'd0);
    chk("rst_bc", 64'(a_bc), 64'd0);
    chk("rst_be", 64'(a_be), 64'hFF);
    chk("rst_busy", 64'(a_busy), 64'd0);
    chk("rst_rdy", 64'(a_rdy), 64'd0);
    chk("rst_err", 64'(a_err), 64'd0);
    chk("rst_dout", a_dout0 | a_dout1, 64'd0);
    chk("rst_b_be", 64'(b_be), 64'hFF);
    chk("rst_b_misc", {b_dout0 | b_dout1, 64'(b_bc)} == 128'd0 ? 64'd0 : 64'd1, 64'd0);
    chk("rst_b_flags", 64'({b_err, b_rd, b_busy, b_rdy}), 64'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_busy", 64'(a_busy), 64'd0);

    // Single reads from the table
    for (int v = 0; v < 5; v++) begin
      s0 = r0_cnt; s1 = r1_cnt; sa = acc_cnt; se = err_cnt;
      pulse(vt[v].p, vt[v].addr, vt[v].bc);
      chk("busy_rise", 64'(a_busy[vt[v].p]), 64'd1);
      issue(vt[v].nbusy, ad_a, ad_b, bc_a, rdc);
      chk("cmd_addr", 64'(ad_a), 64'(vt[v].addr));
      chk("cmd_bc", 64'(bc_a), 64'(vt[v].ebc));
      chk("rd_cycles", 64'(rdc), 64'(vt[v].nbusy + 1));
      chk("rd_low", 64'(a_rd), 64'd0);
      beats(vt[v].p, vt[v].nbeat, 1'b1);
      chk("own_beats", 64'((vt[v].p == 1) ? r1_cnt - s1 : r0_cnt - s0), 64'(vt[v].nbeat));
      chk("other_beats", 64'((vt[v].p == 1) ? r0_cnt - s0 : r1_cnt - s1), 64'd0);
      chk("accepted", 64'(acc_cnt - sa), 64'd1);
      chk("no_err", 64'(err_cnt - se), 64'd0);
    end

    // Ties: a single req1 burst first so req0 should win the next tie
    pulse(1, 29'h0000777, 8'd2);
    issue(0, ad_a, ad_b, bc_a, rdc);
    beats(1, 2, 1'b1);
    raddr[0] = 29'h100; raddr[1] = 29'h200; rbc[0] = 8'd4; rbc[1] = 8'd4;
    rd = 2'b11;
    tick();
    rd = 2'b00;
    issue(0, ad_a, ad_b, bc_a, rdc);
    chk("tieA_1st_rr", 64'(ad_a), 64'h100);
    chk("tieA_1st_fp", 64'(ad_b), 64'h100);
    beats(0, 4, 1'b1);
    issue(0, ad_a, ad_b, bc_a, rdc);
    chk("tieA_2nd_rr", 64'(ad_a), 64'h200);
    chk("tieA_2nd_fp", 64'(ad_b), 64'h200);
    beats(1, 4, 1'b1);
    pulse(0, 29'h300, 8'd4);
    issue(0, ad_a, ad_b, bc_a, rdc);
    beats(0, 4, 1'b1);
    raddr[0] = 29'h400; raddr[1] = 29'h500;
    rd = 2'b11;
    tick();
    rd = 2'b00;
    issue(0, ad_a, ad_b, bc_a, rdc);
    chk("tieB_1st_rr", 64'(ad_a), 64'h500);
    chk("tieB_1st_fp", 64'(ad_b), 64'h400);
    beats(1, 4, 1'b1);
    issue(0, ad_a, ad_b, bc_a, rdc);
    chk("tieB_2nd_rr", 64'(ad_a), 64'h400);
    chk("tieB_2nd_fp", 64'(ad_b), 64'h500);
    beats(0, 4, 1'b1);

    // Watchdog: beats stop after 3 of 8 while req0 waits
    se = err_cnt;
    pulse(1, 29'h600, 8'd8);
    issue(0, ad_a, ad_b, bc_a, rdc);
    beats(1, 3, 1'b0);
    n = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      if (n == 0) begin
        rd[0] = 1'b1; raddr[0] = 29'h700; rbc[0] = 8'd2;
      end
      tick();
      rd[0] = 1'b0;
      n++;
      if (a_err) got = 1'b1;
    end
    chk("wd_delay", 64'(n), 64'd15);
    chk("wd_owner_busy", 64'(a_busy[1]), 64'd1);
    tick();
    chk("wd_err_pulse", 64'(a_err), 64'd0);
    chk("wd_release", 64'(a_busy[1]), 64'd0);
    chk("wd_next_rd", 64'(a_rd), 64'd1);
    chk("wd_next_addr", 64'(a_addr), 64'h700);
    issue(0, ad_a, ad_b, bc_a, rdc);
    beats(0, 2, 1'b1);
    chk("wd_err_once", 64'(err_cnt - se), 64'd1);

    // rd while busy, including the owner's pulse on its final beat
    sa = acc_cnt; se = err_cnt;
    pulse(0, 29'h800, 8'd3);
    chk("rwb_busy", 64'(a_busy[0]), 64'd1);
    pulse(0, 29'h900, 8'd5);
    chk("rwb_err", 64'(a_err), 64'd1);
    issue(0, ad_a, ad_b, bc_a, rdc);
    chk("rwb_addr", 64'(ad_a), 64'h800);
    chk("rwb_bc", 64'(bc_a), 64'd3);
    for (int i = 0; i < 3; i++) begin
      ddram_dout = pat(0, i);
      ddram_dout_ready = 1'b1;
      if (i == 2) rd[0] = 1'b1;
      tick();
      rd[0] = 1'b0;
    end
    ddram_dout_ready = 1'b0;
    chk("rwb_last_err", 64'(a_err), 64'd1);
    tick(); tick(); tick(); tick();
    chk("rwb_no_cmd", 64'(a_rd), 64'd0);
    chk("rwb_accepted", 64'(acc_cnt - sa), 64'd1);
    chk("rwb_errs", 64'(err_cnt - se), 64'd2);

    // Reset in the middle of a burst with beats still arriving
    pulse(0, 29'hA00, 8'd8);
    issue(0, ad_a, ad_b, bc_a, rdc);
    beats(0, 4, 1'b0);
    s0 = r0_cnt; s1 = r1_cnt; se = err_cnt;
    ddram_dout_ready = 1'b1;
    rst = 1'b1;
    tick();
    chk("mrst_be", 64'(a_be), 64'hFF);
    chk("mrst_busy", 64'(a_busy), 64'd0);
    tick();
    rst = 1'b0;
    tick(); tick();
    ddram_dout_ready = 1'b0;
    tick();
    chk("mrst_r0", 64'(r0_cnt - s0), 64'd0);
    chk("mrst_r1", 64'(r1_cnt - s1), 64'd0);
    chk("mrst_err", 64'(err_cnt - se), 64'd0);
    chk("mrst_rd", 64'(a_rd), 64'd0);
    chk("mrst_busy_after", 64'(a_busy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
